// File: rtl/keypad_scanner_pkg.sv
// Shared types and lookup tables for the 4x4 keypad scanner: column strobes,
// key-map table, scan-result classes and debounce FSM states.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_ONE,
    RES_MULTI
  } scan_res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD
  } dbnc_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    case (idx)
      2'd0:    col_strobe = 4'b1110;
      2'd1:    col_strobe = 4'b1101;
      2'd2:    col_strobe = 4'b1011;
      default: col_strobe = 4'b0111;
    endcase
  endfunction

  // Index is 4*column + row.
  function automatic logic [3:0] key_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    key_lut = 4'h1;
      4'd1:    key_lut = 4'h4;
      4'd2:    key_lut = 4'h7;
      4'd3:    key_lut = 4'h0;
      4'd4:    key_lut = 4'h2;
      4'd5:    key_lut = 4'h5;
      4'd6:    key_lut = 4'h8;
      4'd7:    key_lut = 4'hF;
      4'd8:    key_lut = 4'h3;
      4'd9:    key_lut = 4'h6;
      4'd10:   key_lut = 4'h9;
      4'd11:   key_lut = 4'hE;
      4'd12:   key_lut = 4'hA;
      4'd13:   key_lut = 4'hB;
      4'd14:   key_lut = 4'hC;
      default: key_lut = 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Scan-rate debounce FSM: accepts a single steady key after DEBOUNCE_SCANS
// scans and locks out new keys until DEBOUNCE_SCANS empty scans are seen.
module key_debounce_fsm
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_end,
  input  logic [1:0] res,
  input  logic [3:0] key,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [8:0] DS = 9'(DEBOUNCE_SCANS);

  dbnc_state_t state;
  logic [3:0]  cand;
  logic [7:0]  cnt;
  logic [7:0]  rel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      rel       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        case (state)
          ST_IDLE: begin
            if (scan_res_t'(res) == RES_ONE) begin
              state <= ST_DEBOUNCE;
              cand  <= key;
              cnt   <= 8'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (scan_res_t'(res) == RES_ONE) begin
              if (key != cand) begin
                cand <= key;
                cnt  <= 8'd1;
              end else if ({1'b0, cnt} + 9'd1 == DS) begin
                state     <= ST_HELD;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rel       <= '0;
              end else if (cnt != '1) begin
                cnt <= cnt + 8'd1;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (scan_res_t'(res) == RES_NONE) begin
              if ({1'b0, rel} + 9'd1 == DS) begin
                state    <= ST_IDLE;
                key_held <= 1'b0;
                rel      <= '0;
              end else if (rel != '1) begin
                rel <= rel + 8'd1;
              end
            end else begin
              rel <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: active-low column strobing, row synchronizer,
// per-scan press map and decode, feeding the debounce FSM.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [15:0]   map;
  logic [15:0]   map_next;
  logic          last_dwell;
  logic          scan_end;
  logic [4:0]    nset;
  logic [3:0]    kidx;
  logic [3:0]    key;
  scan_res_t     res;

  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign scan_end   = last_dwell && (col_idx == 2'd3);

  // Sample folds into the map combinationally so scan_end evaluates its own column-3 sample.
  always_comb begin
    map_next = map;
    if (last_dwell)
      map_next = map | ({12'b0, ~row_s2} << {col_idx, 2'b00});
  end

  always_comb begin
    nset = '0;
    kidx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (map_next[i]) begin
        nset = nset + 5'd1;
        kidx = 4'(i);
      end
    end
    if (nset == 5'd0)      res = RES_NONE;
    else if (nset == 5'd1) res = RES_ONE;
    else                   res = RES_MULTI;
    key = key_lut(kidx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1  <= '1;
      row_s2  <= '1;
      dwell   <= '0;
      col_idx <= '0;
      col     <= COL_RESET;
      map     <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (last_dwell) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= col_strobe(col_idx + 2'd1);
        map     <= scan_end ? '0 : map_next;
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  key_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .scan_end (scan_end),
    .res      (res),
    .key      (key),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

endmodule
